// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry word sequencer.
package rca_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rca_seq_state_t;

endpackage : rca_pkg

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder: a chain of full adders, carry rippling LSB to MSB.
module ripple_carry_adder
    import rca_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_cout
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar g = 0; g < NIBBLE_W; g++) begin : g_fa
            assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
            assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
        end
    endgenerate

    assign o_cout = w_c[NIBBLE_W];

endmodule : ripple_carry_adder

// File: rtl/rca_word_sequencer.sv
// Wide-word adder that reuses one 4-bit ripple_carry_adder, one nibble per
// cycle, LSB first, with the inter-nibble carry held in a register.
// Optional feature macro: SUB_EN adds i_op_sub for A-B (two's complement).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Input side: o_in_ready is high only in IDLE. Output side: o_out_valid is
// high only in DONE; o_result/o_cout are held stable until i_out_ready is seen.
module rca_word_sequencer
    import rca_pkg::*;
#(
    parameter int WORDS = 4
)
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [4*WORDS-1:0]     i_op_a,
    input  logic [4*WORDS-1:0]     i_op_b,
    input  logic                   i_op_cin,
`ifdef SUB_EN
    input  logic                   i_op_sub,
`endif
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [4*WORDS-1:0]     o_result,
    output logic                   o_cout,
    output logic                   o_busy,
    output logic [1:0]             o_state
);

    localparam int W     = NIBBLE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    rca_seq_state_t r_state;
    rca_seq_state_t w_state_nxt;

    logic [W-1:0]        r_a_sr;
    logic [W-1:0]        r_b_sr;
    logic                r_carry;
    logic [IDX_W-1:0]    r_idx;
    logic [W-1:0]        r_result;
    logic                r_cout;

    logic                w_accept;
    logic                w_last;
    logic [W-1:0]        w_b_load;
    logic                w_cin_load;
    logic [NIBBLE_W-1:0] w_sum;
    logic                w_carry;
    logic [W-1:0]        w_result_nxt;

    // Subtraction feeds ~B with a forced carry-in of 1; otherwise plain add.
`ifdef SUB_EN
    assign w_b_load   = i_op_sub ? ~i_op_b : i_op_b;
    assign w_cin_load = i_op_sub ? 1'b1    : i_op_cin;
`else
    assign w_b_load   = i_op_b;
    assign w_cin_load = i_op_cin;
`endif

    ripple_carry_adder u_rca (
        .i_a    (r_a_sr[NIBBLE_W-1:0]),
        .i_b    (r_b_sr[NIBBLE_W-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_carry)
    );

    // New nibble enters at the top of the result and shifts down each RUN cycle.
    generate
        if (WORDS == 1) begin : g_one_word
            assign w_result_nxt = w_sum;
        end else begin : g_multi_word
            assign w_result_nxt = {w_sum, r_result[W-1:NIBBLE_W]};
        end
    endgenerate

    assign w_accept = i_in_valid && (r_state == IDLE);
    assign w_last   = (r_idx == LAST_IDX);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, nibble-serial datapath and result hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= i_op_a;
            r_b_sr  <= w_b_load;
            r_carry <= w_cin_load;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_result <= w_result_nxt;
            r_carry  <= w_carry;
            r_a_sr   <= r_a_sr >> NIBBLE_W;
            r_b_sr   <= r_b_sr >> NIBBLE_W;
            r_idx    <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_cout <= w_carry;
            end
        end
    end

    assign o_result = r_result;
    assign o_cout   = r_cout;
    assign o_state  = r_state;

endmodule : rca_word_sequencer

// File: tb/tb_rca_word_sequencer.sv
// Bench for rca_word_sequencer: a WORDS=4 instance driven with directed and
// random transactions, plus a WORDS=1 instance for the single-nibble case.
module tb_rca_word_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;
    localparam int TMO   = 40;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         busy;
    logic [1:0]   state;

    logic         u1_in_valid;
    logic         u1_in_ready;
    logic [3:0]   u1_op_a;
    logic [3:0]   u1_op_b;
    logic         u1_op_cin;
    logic         u1_op_sub;
    logic         u1_out_valid;
    logic         u1_out_ready;
    logic [3:0]   u1_result;
    logic         u1_cout;
    logic         u1_busy;
    logic [1:0]   u1_state;

    int n_cmp;
    int n_err;
    logic [W:0] exp_q[$];

    rca_word_sequencer #(.WORDS(WORDS)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .i_op_cin    (op_cin),
`ifdef SUB_EN
        .i_op_sub    (op_sub),
`endif
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_result    (result),
        .o_cout      (cout),
        .o_busy      (busy),
        .o_state     (state)
    );

    rca_word_sequencer #(.WORDS(1)) dut1 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (u1_in_valid),
        .o_in_ready  (u1_in_ready),
        .i_op_a      (u1_op_a),
        .i_op_b      (u1_op_b),
        .i_op_cin    (u1_op_cin),
`ifdef SUB_EN
        .i_op_sub    (u1_op_sub),
`endif
        .o_out_valid (u1_out_valid),
        .i_out_ready (u1_out_ready),
        .o_result    (u1_result),
        .o_cout      (u1_cout),
        .o_busy      (u1_busy),
        .o_state     (u1_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-word arithmetic, {carry, sum}.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        logic [W:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else     r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        return r;
    endfunction

    // One full transaction on the WORDS=4 instance; returns what the DUT produced.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub, input bit early, input int hold,
                           output logic [W:0] got);
        logic [W:0] exp;
        int lat;
        exp_q.push_back(model(a, b, cin, sub));
        got = '0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL txn_in_ready got=%b exp=1", in_ready);
        end
        in_valid = 1'b1; op_a = a; op_b = b; op_cin = cin; op_sub = sub; out_ready = early;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom);
        op_sub = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < TMO) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++; $display("FAIL busy_run got=%b exp=1 cyc=%0d", busy, lat);
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if (lat >= TMO) begin
            n_err++; $display("FAIL out_valid_timeout got=%0d exp=%0d", lat, WORDS);
            out_ready = 1'b0;
            return;
        end
        if (lat != WORDS) begin
            n_err++; $display("FAIL latency got=%0d exp=%0d", lat, WORDS);
        end
        got = {cout, result};
        n_cmp++;
        if ({cout, result} !== exp) begin
            n_err++; $display("FAIL sum a=%h b=%h cin=%b sub=%b got=%h exp=%h", a, b, cin, sub,
                              {cout, result}, exp);
        end
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL done_flags busy=%b in_ready=%b exp=1/0", busy, in_ready);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({cout, result} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++; $display("FAIL hold got=%h ov=%b ir=%b exp=%h ov=1 ir=0",
                                  {cout, result}, out_valid, in_ready, exp);
            end
        end
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL handshake ov=%b ir=%b busy=%b exp=0/1/0",
                              out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            result !== '0 || cout !== 1'b0) begin
            n_err++; $display("FAIL reset ir=%b ov=%b busy=%b res=%h cout=%b exp=1/0/0/0/0",
                              in_ready, out_valid, busy, result, cout);
        end
        n_cmp++;
        if (u1_in_ready !== 1'b1 || u1_out_valid !== 1'b0 || u1_result !== 4'h0) begin
            n_err++; $display("FAIL reset_w1 ir=%b ov=%b res=%h exp=1/0/0",
                              u1_in_ready, u1_out_valid, u1_result);
        end
    endtask

    task automatic test_directed;
        logic [W:0] got;
        run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, got);
        n_cmp++;
        if (got !== 17'h1_0000) begin
            n_err++; $display("FAIL dir_ffff got=%h exp=10000", got);
        end
        run_txn(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 2, got);
        n_cmp++;
        if (got !== 17'h0_5556) begin
            n_err++; $display("FAIL dir_1234 got=%h exp=05556", got);
        end
        run_txn(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 0, got);
        n_cmp++;
        if (got !== 17'h1_0000) begin
            n_err++; $display("FAIL dir_wrap got=%h exp=10000", got);
        end
    endtask

    task automatic test_hold_done;
        logic [W:0] got;
        run_txn(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 1'b0, 10, got);
        n_cmp++;
        if (got !== 17'h1_0000) begin
            n_err++; $display("FAIL hold_sum got=%h exp=10000", got);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [W:0] got;
        @(negedge clk);
        in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0; op_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            result !== '0 || cout !== 1'b0) begin
            n_err++; $display("FAIL rst_mid ir=%b ov=%b busy=%b res=%h cout=%b exp=1/0/0/0/0",
                              in_ready, out_valid, busy, result, cout);
        end
        run_txn(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 0, got);
        n_cmp++;
        if (got !== 17'h0_0007) begin
            n_err++; $display("FAIL rst_then_add got=%h exp=00007", got);
        end
    endtask

`ifdef SUB_EN
    task automatic test_sub;
        logic [W:0] got;
        run_txn(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 0, got);
        n_cmp++;
        if (got !== 17'h0_FFFE) begin
            n_err++; $display("FAIL sub_neg got=%h exp=0fffe", got);
        end
        run_txn(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0, 0, got);
        n_cmp++;
        if (got !== 17'h1_0002) begin
            n_err++; $display("FAIL sub_pos got=%h exp=10002", got);
        end
    endtask
`endif

    task automatic test_random;
        logic [W:0] got;
        logic sub;
        bit early;
        for (int i = 0; i < 40; i++) begin
`ifdef SUB_EN
            sub = 1'($urandom_range(0, 1));
`else
            sub = 1'b0;
`endif
            early = 1'($urandom_range(0, 1));
            run_txn(W'($urandom), W'($urandom), 1'($urandom), sub, early,
                    early ? 0 : int'($urandom_range(0, 3)), got);
        end
    endtask

    task automatic test_back_to_back;
        logic [W:0] got;
        for (int i = 0; i < 6; i++) begin
            run_txn(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1, 0, got);
        end
    endtask

    task automatic test_words1;
        logic [4:0] exp;
        logic [3:0] a, b;
        logic       c;
        int lat;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin a = 4'hF; b = 4'h1; c = 1'b1; end
            else begin a = 4'($urandom); b = 4'($urandom); c = 1'($urandom); end
            exp = {1'b0, a} + {1'b0, b} + 5'(c);
            @(negedge clk);
            u1_in_valid = 1'b1; u1_op_a = a; u1_op_b = b; u1_op_cin = c; u1_op_sub = 1'b0;
            @(posedge clk);
            @(negedge clk);
            u1_in_valid = 1'b0;
            lat = 0;
            while (u1_out_valid !== 1'b1 && lat < TMO) begin
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
            n_cmp++;
            if (lat != 1) begin
                n_err++; $display("FAIL w1_latency got=%0d exp=1", lat);
            end
            n_cmp++;
            if ({u1_cout, u1_result} !== exp) begin
                n_err++; $display("FAIL w1_sum a=%h b=%h cin=%b got=%h exp=%h", a, b, c,
                                  {u1_cout, u1_result}, exp);
            end
            u1_out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            u1_out_ready = 1'b0;
            n_cmp++;
            if (u1_out_valid !== 1'b0 || u1_in_ready !== 1'b1) begin
                n_err++; $display("FAIL w1_handshake ov=%b ir=%b exp=0/1",
                                  u1_out_valid, u1_in_ready);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0; out_ready = 1'b0;
        u1_in_valid = 1'b0; u1_op_a = '0; u1_op_b = '0; u1_op_cin = 1'b0; u1_op_sub = 1'b0;
        u1_out_ready = 1'b0;
        test_reset();
        test_directed();
        test_hold_done();
        test_reset_mid_run();
`ifdef SUB_EN
        test_sub();
`endif
        test_random();
        test_back_to_back();
        test_words1();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rca_word_sequencer
